// File: rtl/fp_pkg.sv
// Shared definitions for the small sign/exponent/mantissa float datapath:
// default field widths, mode encodings and field-slice helpers.
package fp_pkg;

  localparam int EXP_BITS_DEF  = 4;
  localparam int MANT_BITS_DEF = 3;
  localparam int BIAS_DEF      = (2 ** (EXP_BITS_DEF - 1)) - 1;

  localparam logic MODE_APPROX = 1'b0;
  localparam logic MODE_EXACT  = 1'b1;

  // Helpers work on a zero-extended 32-bit word so one definition serves any width.
  function automatic logic fld_sign(input logic [31:0] x, input int eb, input int mb);
    logic [31:0] t;
    t = x >> (eb + mb);
    return t[0];
  endfunction

  function automatic logic [31:0] fld_exp(input logic [31:0] x, input int eb, input int mb);
    logic [31:0] t;
    t = x >> mb;
    return t & ((32'd1 << eb) - 32'd1);
  endfunction

  function automatic logic [31:0] fld_mant(input logic [31:0] x, input int mb);
    return x & ((32'd1 << mb) - 32'd1);
  endfunction

endpackage

// File: rtl/fp_mant_core.sv
// Combinational mantissa datapath: Mitchell log-domain add or exact
// truncating multiply of the two significands.
module fp_mant_core
  import fp_pkg::*;
#(
  parameter int MANT_BITS = MANT_BITS_DEF
) (
  input  logic [MANT_BITS-1:0] ma_i,
  input  logic [MANT_BITS-1:0] mb_i,
  input  logic                 mode_i,
  output logic [MANT_BITS-1:0] mant_o,
  output logic                 c_o
);

  localparam int PW = 2 * MANT_BITS + 2;

  logic [MANT_BITS:0]   sum;
  logic [PW-1:0]        prod;
  logic [MANT_BITS+1:0] p_top;

  assign sum  = {1'b0, ma_i} + {1'b0, mb_i};
  assign prod = PW'({1'b1, ma_i}) * PW'({1'b1, mb_i});
  // Product lies in [1,4): keep the carry bit and the two candidate fraction windows.
  assign p_top = (MANT_BITS + 2)'(prod >> MANT_BITS);

  always_comb begin
    c_o    = sum[MANT_BITS];
    mant_o = sum[MANT_BITS-1:0];
    if (mode_i == MODE_EXACT) begin
      c_o    = p_top[MANT_BITS+1];
      mant_o = p_top[MANT_BITS+1] ? p_top[MANT_BITS:1] : p_top[MANT_BITS-1:0];
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Two-stage pipelined float multiplier with valid/ready handshakes,
// overflow/underflow/zero flags and sticky status bits.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_BITS  = EXP_BITS_DEF,
  parameter int MANT_BITS = MANT_BITS_DEF,
  parameter int W         = 1 + EXP_BITS + MANT_BITS,
  parameter int BIAS      = (2 ** (EXP_BITS - 1)) - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_p,
  output logic         out_of,
  output logic         out_uf,
  output logic         out_zero,
  output logic         sticky_of,
  output logic         sticky_uf,
  input  logic         sticky_clr
);

  localparam int EB2   = EXP_BITS + 2;
  localparam int MAX_E = (2 ** EXP_BITS) - 1;

  logic                 sign_a, sign_b;
  logic [EXP_BITS-1:0]  ea, eb;
  logic [MANT_BITS-1:0] ma, mb, core_mant;
  logic                 core_c;
  logic [EB2-1:0]       esum;

  assign sign_a = fld_sign(32'(in_a), EXP_BITS, MANT_BITS);
  assign sign_b = fld_sign(32'(in_b), EXP_BITS, MANT_BITS);
  assign ea     = EXP_BITS'(fld_exp(32'(in_a), EXP_BITS, MANT_BITS));
  assign eb     = EXP_BITS'(fld_exp(32'(in_b), EXP_BITS, MANT_BITS));
  assign ma     = MANT_BITS'(fld_mant(32'(in_a), MANT_BITS));
  assign mb     = MANT_BITS'(fld_mant(32'(in_b), MANT_BITS));
  // Two guard bits keep the biased sum signed and unclipped in two's complement.
  assign esum   = EB2'(ea) + EB2'(eb) - EB2'(BIAS);

  fp_mant_core #(.MANT_BITS(MANT_BITS)) u_core (
    .ma_i  (ma),
    .mb_i  (mb),
    .mode_i(in_mode),
    .mant_o(core_mant),
    .c_o   (core_c)
  );

  logic                 s1_valid_q, s1_sign_q, s1_zero_q, s1_c_q;
  logic [EB2-1:0]       s1_esum_q;
  logic [MANT_BITS-1:0] s1_mant_q;

  logic                 s2_valid_q, of_q, uf_q, zero_q;
  logic [W-1:0]         p_q;
  logic                 sticky_of_q, sticky_uf_q;

  logic                 s2_adv;
  logic [EB2-1:0]       e_full;
  logic                 e_neg, e_le0, e_big;
  logic [W-1:0]         p_d;
  logic                 of_d, uf_d, zero_d;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | ~s2_valid_q | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_c_q     <= 1'b0;
      s1_esum_q  <= '0;
      s1_mant_q  <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= sign_a ^ sign_b;
        s1_zero_q <= (ea == '0) | (eb == '0);
        s1_c_q    <= core_c;
        s1_esum_q <= esum;
        s1_mant_q <= core_mant;
      end
    end
  end

  assign e_full = s1_esum_q + EB2'(s1_c_q);
  assign e_neg  = e_full[EB2-1];
  assign e_le0  = e_neg | (e_full == '0);
  assign e_big  = ~e_neg & (e_full > EB2'(MAX_E));

  always_comb begin
    p_d    = {s1_sign_q, e_full[EXP_BITS-1:0], s1_mant_q};
    of_d   = 1'b0;
    uf_d   = 1'b0;
    zero_d = 1'b0;
    if (s1_zero_q) begin
      p_d    = {s1_sign_q, {(W-1){1'b0}}};
      zero_d = 1'b1;
    end else if (e_le0) begin
      p_d    = {s1_sign_q, {(W-1){1'b0}}};
      uf_d   = 1'b1;
      zero_d = 1'b1;
    end else if (e_big) begin
      p_d    = {s1_sign_q, {(W-1){1'b1}}};
      of_d   = 1'b1;
    end
  end

  // Output registers only move on a downstream transfer, so a stalled result holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      p_q        <= '0;
      of_q       <= 1'b0;
      uf_q       <= 1'b0;
      zero_q     <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        p_q    <= p_d;
        of_q   <= of_d;
        uf_q   <= uf_d;
        zero_q <= zero_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_of_q <= 1'b0;
      sticky_uf_q <= 1'b0;
    end else begin
      if (s2_valid_q & out_ready & of_q) sticky_of_q <= 1'b1;
      else if (sticky_clr)               sticky_of_q <= 1'b0;
      if (s2_valid_q & out_ready & uf_q) sticky_uf_q <= 1'b1;
      else if (sticky_clr)               sticky_uf_q <= 1'b0;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_p     = p_q;
  assign out_of    = of_q;
  assign out_uf    = uf_q;
  assign out_zero  = zero_q;
  assign sticky_of = sticky_of_q;
  assign sticky_uf = sticky_uf_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (E4M3): directed corner cases, backpressure,
// randomized traffic against a value-level reference model, reset and sticky behaviour.
module tb_fp_mul_pipe;

  localparam int EB   = 4;
  localparam int MB   = 3;
  localparam int W    = 8;
  localparam int BIAS = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, in_ready, in_mode;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready;
  logic [W-1:0] out_p;
  logic         out_of, out_uf, out_zero;
  logic         sticky_of, sticky_uf, sticky_clr;

  always #5 clk = ~clk;

  fp_mul_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_of    (out_of),
    .out_uf    (out_uf),
    .out_zero  (out_zero),
    .sticky_of (sticky_of),
    .sticky_uf (sticky_uf),
    .sticky_clr(sticky_clr)
  );

  typedef struct {
    logic [W-1:0] p;
    bit           of_f;
    bit           uf_f;
    bit           zero_f;
    bit           lat;
    int           icyc;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pushed = 0;
  int   popped = 0;
  bit   exp_sticky_of = 0;
  bit   exp_sticky_uf = 0;
  bit   stim_done = 0;
  logic [W-1:0] ra, rb;
  bit   rm;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] p, input bit o, input bit u, input bit z);
    exp_t r;
    r.p = p; r.of_f = o; r.uf_f = u; r.zero_f = z;
    r.lat = 0; r.icyc = 0; r.a = '0; r.b = '0;
    return r;
  endfunction

  // Value-level reference: significands as scaled integers, product value in [1,4).
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit mode);
    exp_t r;
    int f, ea, eb, ma, mb, c, mant, e, prod, sgn;
    f    = 1 << MB;
    sgn  = int'(a[W-1] ^ b[W-1]);
    ea   = int'(a[W-2:MB]);
    eb   = int'(b[W-2:MB]);
    ma   = int'(a[MB-1:0]);
    mb   = int'(b[MB-1:0]);
    r    = mk('0, 0, 0, 0);
    c    = 0;
    if (mode) begin
      prod = (f + ma) * (f + mb);
      if (prod >= 2 * f * f) begin
        c    = 1;
        mant = (prod - 2 * f * f) / (2 * f);
      end else begin
        mant = (prod - f * f) / f;
      end
    end else begin
      mant = ma + mb;
      if (mant >= f) begin
        c    = 1;
        mant = mant - f;
      end
    end
    e = ea + eb - BIAS + c;
    if (ea == 0 || eb == 0) begin
      r.p = W'(sgn << (W - 1));
      r.zero_f = 1;
    end else if (e <= 0) begin
      r.p = W'(sgn << (W - 1));
      r.uf_f = 1;
      r.zero_f = 1;
    end else if (e > (1 << EB) - 1) begin
      r.p = W'((sgn << (W - 1)) | ((1 << (W - 1)) - 1));
      r.of_f = 1;
    end else begin
      r.p = W'((sgn << (W - 1)) | (e << MB) | mant);
    end
    return r;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit mode,
                      input exp_t e, input bit lat);
    int n;
    n = 0;
    in_a = a; in_b = b; in_mode = mode; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e.lat = lat; e.icyc = cyc; e.a = a; e.b = b;
        sb.push_back(e);
        pushed++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      n++;
      if (n > 100) begin
        chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [W-1:0] pp;
    logic [2:0]   pf;
    bit           stalled;
    exp_t         e;
    stalled = 0;
    pp = '0;
    pf = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 0;
        continue;
      end
      if (stalled) begin
        chk("hold_p", int'(out_p), int'(pp));
        chk("hold_flags", int'({out_of, out_uf, out_zero}), int'(pf));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", int'(out_p), -1);
        end else begin
          e = sb.pop_front();
          popped++;
          $display("txn a=%02h b=%02h p=%02h of=%0b uf=%0b zero=%0b", e.a, e.b, out_p, out_of, out_uf, out_zero);
          chk("out_p", int'(out_p), int'(e.p));
          chk("out_of", int'(out_of), int'(e.of_f));
          chk("out_uf", int'(out_uf), int'(e.uf_f));
          chk("out_zero", int'(out_zero), int'(e.zero_f));
          if (e.lat) chk("latency", cyc - e.icyc, 2);
          exp_sticky_of = exp_sticky_of | e.of_f;
          exp_sticky_uf = exp_sticky_uf | e.uf_f;
        end
      end
      stalled = out_valid && !out_ready;
      pp = out_p;
      pf = {out_of, out_uf, out_zero};
    end
  endtask

  initial begin
    int n;
    in_valid = 0; in_a = '0; in_b = '0; in_mode = 0;
    out_ready = 1; sticky_clr = 0; rst_n = 0;
    fork
      monitor();
      forever begin @(posedge clk); cyc++; end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_p", int'(out_p), 0);
    chk("rst_flags", int'({out_of, out_uf, out_zero}), 0);
    chk("rst_sticky", int'({sticky_of, sticky_uf}), 0);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Directed corner cases
    send(8'h38, 8'h38, 0, mk(8'h38, 0, 0, 0), 1); drain();
    send(8'h38, 8'h38, 1, mk(8'h38, 0, 0, 0), 1); drain();
    send(8'h3C, 8'h3C, 0, mk(8'h40, 0, 0, 0), 0);
    send(8'h3C, 8'h3C, 1, mk(8'h41, 0, 0, 0), 0);
    send(8'hB8, 8'h38, 1, mk(8'hB8, 0, 0, 0), 0);
    send(8'h77, 8'h77, 0, mk(8'h7F, 1, 0, 0), 0);
    send(8'h08, 8'h08, 1, mk(8'h00, 0, 1, 1), 0);
    send(8'h80, 8'h77, 1, mk(8'h80, 0, 0, 1), 0);
    drain();
    chk("sticky_of_set", int'(sticky_of), 1);
    chk("sticky_uf_set", int'(sticky_uf), 1);
    sticky_clr = 1;
    @(posedge clk);
    #1;
    sticky_clr = 0;
    chk("sticky_clr", int'({sticky_of, sticky_uf}), 0);
    exp_sticky_of = 0;
    exp_sticky_uf = 0;

    // Backpressure: 8 back-to-back ops, downstream stalls 3 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ra = W'($urandom); rb = W'($urandom); rm = 1'($urandom);
          send(ra, rb, rm, model(ra, rb, rm), 0);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 0;
        @(negedge clk);
        chk("in_ready_full", int'(in_ready), 0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    drain();
    chk("bp_count", popped, pushed);

    // Randomized traffic with random downstream stalls
    stim_done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          ra = W'($urandom); rb = W'($urandom); rm = 1'($urandom);
          send(ra, rb, rm, model(ra, rb, rm), 0);
        end
        stim_done = 1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join
    drain();
    chk("rand_count", popped, pushed);
    chk("rand_sticky_of", int'(sticky_of), int'(exp_sticky_of));
    chk("rand_sticky_uf", int'(sticky_uf), int'(exp_sticky_uf));

    // Reset with two operations in flight
    out_ready = 0;
    send(8'h40, 8'h40, 1, mk(8'h48, 0, 0, 0), 0);
    send(8'h48, 8'h40, 1, mk(8'h50, 0, 0, 0), 0);
    chk("pre_reset_valid", int'(out_valid), 1);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_in_ready", int'(in_ready), 1);
    chk("async_rst_out_p", int'(out_p), 0);
    chk("async_rst_sticky", int'({sticky_of, sticky_uf}), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;

    // Clear coincident with an overflow result transfer: the set wins
    out_ready = 0;
    send(8'h77, 8'h77, 1, mk(8'h7F, 1, 0, 0), 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ovf_presented", int'(out_valid), 1);
    chk("sticky_before", int'(sticky_of), 0);
    @(posedge clk);
    #1;
    sticky_clr = 1;
    out_ready = 1;
    @(posedge clk);
    #1;
    sticky_clr = 0;
    chk("sticky_set_wins", int'(sticky_of), 1);
    chk("sticky_uf_cleared", int'(sticky_uf), 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
